// File: rtl/cart_mem_arbiter.sv
// Cartridge memory port arbiter.
// Shares one SDRAM cartridge window among the ROM downloader (dl), the CPU-side
// mapper (cpu) and the SRAM backup engine (bk). Only one access is in flight at a
// time. Priority is dl > cpu > bk. When the CPU has been granted BK_STARVE times in
// a row while bk waited, bk is granted ahead of the CPU.
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   dl_req/addr/data, dl_ack         downloader write port
//   cpu_req/we/addr/din, cpu_dout,
//   cpu_ack, cpu_wait                mapper port; cpu_wait is combinational Z80 WAIT
//   bk_req/we/addr/din, bk_dout,
//   bk_ack, bk_err                   backup port; bk_err flags a timed-out access
//   mem_addr/dout/din, mem_rd,
//   mem_we, mem_ready                SDRAM controller port
module cart_mem_arbiter #(
    parameter int unsigned AW        = 25,
    parameter int unsigned BK_STARVE = 4,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          dl_req,
    input  logic [AW-1:0] dl_addr,
    input  logic [7:0]    dl_data,
    output logic          dl_ack,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_din,
    output logic [7:0]    cpu_dout,
    output logic          cpu_ack,
    output logic          cpu_wait,
    input  logic          bk_req,
    input  logic          bk_we,
    input  logic [AW-1:0] bk_addr,
    input  logic [7:0]    bk_din,
    output logic [7:0]    bk_dout,
    output logic          bk_ack,
    output logic          bk_err,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_dout,
    input  logic [7:0]    mem_din,
    output logic          mem_rd,
    output logic          mem_we,
    input  logic          mem_ready
);

    localparam int unsigned SW = $clog2(BK_STARVE + 1);
    localparam int unsigned TW = 8;
    localparam logic [SW-1:0] STARVE_MAX = SW'(BK_STARVE);
    localparam logic [TW-1:0] TMO_MAX    = TW'(TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;
    typedef enum logic [1:0] {OWN_DL, OWN_CPU, OWN_BK} owner_t;

    state_t          state, state_d;
    owner_t          owner, owner_d;
    logic            we_q, we_d;
    logic [SW-1:0]   starve, starve_d;
    logic [TW-1:0]   tmo, tmo_d;
    logic [AW-1:0]   mem_addr_d;
    logic [7:0]      mem_dout_d, cpu_dout_d, bk_dout_d;
    logic            dl_ack_d, cpu_ack_d, bk_ack_d, bk_err_d, mem_rd_d, mem_we_d;

    logic            grant, done, load, cpu_blocked;
    logic [7:0]      rdata;

    // WAIT goes away in the same cycle the ack pulse is seen
    assign cpu_wait = cpu_req & ~cpu_ack;

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            owner    <= OWN_DL;
            we_q     <= 1'b0;
            starve   <= '0;
            tmo      <= '0;
            mem_addr <= '0;
            mem_dout <= '0;
            cpu_dout <= '0;
            bk_dout  <= '0;
            dl_ack   <= 1'b0;
            cpu_ack  <= 1'b0;
            bk_ack   <= 1'b0;
            bk_err   <= 1'b0;
            mem_rd   <= 1'b0;
            mem_we   <= 1'b0;
        end else begin
            state    <= state_d;
            owner    <= owner_d;
            we_q     <= we_d;
            starve   <= starve_d;
            tmo      <= tmo_d;
            mem_addr <= mem_addr_d;
            mem_dout <= mem_dout_d;
            cpu_dout <= cpu_dout_d;
            bk_dout  <= bk_dout_d;
            dl_ack   <= dl_ack_d;
            cpu_ack  <= cpu_ack_d;
            bk_ack   <= bk_ack_d;
            bk_err   <= bk_err_d;
            mem_rd   <= mem_rd_d;
            mem_we   <= mem_we_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d     = state;
        owner_d     = owner;
        we_d        = we_q;
        starve_d    = starve;
        tmo_d       = tmo;
        mem_addr_d  = mem_addr;
        mem_dout_d  = mem_dout;
        cpu_dout_d  = cpu_dout;
        bk_dout_d   = bk_dout;
        bk_err_d    = bk_err;
        dl_ack_d    = 1'b0;
        cpu_ack_d   = 1'b0;
        bk_ack_d    = 1'b0;
        mem_rd_d    = 1'b0;
        mem_we_d    = 1'b0;
        grant       = 1'b0;
        done        = 1'b0;
        load        = 1'b0;
        rdata       = 8'h00;
        cpu_blocked = bk_req && (starve == STARVE_MAX);

        // Starvation only counts while bk is actually waiting
        if (!bk_req) starve_d = '0;

        unique case (state)
            S_IDLE: begin
                if (dl_req) begin
                    grant      = 1'b1;
                    owner_d    = OWN_DL;
                    mem_addr_d = dl_addr;
                    mem_dout_d = dl_data;
                    we_d       = 1'b1;
                end else if (cpu_req && !cpu_blocked) begin
                    grant      = 1'b1;
                    owner_d    = OWN_CPU;
                    mem_addr_d = cpu_addr;
                    mem_dout_d = cpu_din;
                    we_d       = cpu_we;
                    if (bk_req && (starve != STARVE_MAX)) starve_d = starve + SW'(1);
                end else if (bk_req) begin
                    grant      = 1'b1;
                    owner_d    = OWN_BK;
                    mem_addr_d = bk_addr;
                    mem_dout_d = bk_din;
                    we_d       = bk_we;
                    starve_d   = '0;
                end
                // Strobe is registered so it is high for the whole ISSUE cycle
                if (grant) begin
                    state_d  = S_ISSUE;
                    bk_err_d = 1'b0;
                    mem_rd_d = ~we_d;
                    mem_we_d = we_d;
                end
            end
            S_ISSUE: begin
                tmo_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (mem_ready) begin
                    done  = 1'b1;
                    load  = ~we_q;
                    rdata = mem_din;
                end else if (tmo == TMO_MAX) begin
                    done     = 1'b1;
                    load     = ~we_q;
                    rdata    = 8'hFF;
                    bk_err_d = 1'b1;
                end else begin
                    tmo_d = tmo + TW'(1);
                end
                // Ack and read data are registered together so dout is valid with ack
                if (done) begin
                    state_d = S_DONE;
                    case (owner)
                        OWN_DL:  dl_ack_d  = 1'b1;
                        OWN_CPU: begin
                            cpu_ack_d = 1'b1;
                            if (load) cpu_dout_d = rdata;
                        end
                        OWN_BK:  begin
                            bk_ack_d = 1'b1;
                            if (load) bk_dout_d = rdata;
                        end
                        default: ;
                    endcase
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_cart_mem_arbiter.sv
// Self-checking bench for cart_mem_arbiter: a table of single transactions plus
// hand-written sequences for arbitration order, starvation, timeout and reset.
module tb_cart_mem_arbiter;

    localparam int unsigned AW = 25;

    logic          clk = 1'b0;
    logic          reset;
    logic          dl_req, cpu_req, cpu_we, bk_req, bk_we, mem_ready;
    logic [AW-1:0] dl_addr, cpu_addr, bk_addr;
    logic [7:0]    dl_data, cpu_din, bk_din, mem_din;
    logic          dl_ack, cpu_ack, cpu_wait, bk_ack, bk_err, mem_rd, mem_we;
    logic [7:0]    cpu_dout, bk_dout, mem_dout;
    logic [AW-1:0] mem_addr;

    int errors = 0;
    int checks = 0;
    int strobes = 0;

    always #5 clk = ~clk;

    always @(negedge clk) if (mem_rd || mem_we) strobes++;

    cart_mem_arbiter #(.AW(AW), .BK_STARVE(4), .TIMEOUT(255)) dut (
        .clk(clk), .reset(reset),
        .dl_req(dl_req), .dl_addr(dl_addr), .dl_data(dl_data), .dl_ack(dl_ack),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .cpu_dout(cpu_dout), .cpu_ack(cpu_ack), .cpu_wait(cpu_wait),
        .bk_req(bk_req), .bk_we(bk_we), .bk_addr(bk_addr), .bk_din(bk_din),
        .bk_dout(bk_dout), .bk_ack(bk_ack), .bk_err(bk_err),
        .mem_addr(mem_addr), .mem_dout(mem_dout), .mem_din(mem_din),
        .mem_rd(mem_rd), .mem_we(mem_we), .mem_ready(mem_ready)
    );

    // src: 0=dl 1=cpu 2=bk; exp_dout is the owner's dout after ack (held value on writes)
    typedef struct {
        int          src;
        logic        we;
        logic [24:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  rdata;
        int          delay;
        logic [7:0]  exp_dout;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_req(input int src, input logic we, input logic [24:0] addr,
                           input logic [7:0] data);
        case (src)
            0: begin dl_req = 1'b1; dl_addr = addr; dl_data = data; end
            1: begin cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_din = data; end
            default: begin bk_req = 1'b1; bk_we = we; bk_addr = addr; bk_din = data; end
        endcase
    endtask

    task automatic drop(input logic [2:0] mask);
        if (mask[0]) dl_req = 1'b0;
        if (mask[1]) cpu_req = 1'b0;
        if (mask[2]) bk_req = 1'b0;
    endtask

    task automatic wait_strobe(output logic seen);
        seen = 1'b0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (mem_rd || mem_we) begin
                seen = 1'b1;
                break;
            end
        end
        chk("strobe_seen", 32'(seen), 32'd1);
    endtask

    // Serves one granted access: checks strobe, returns mem_ready after delay, checks ack
    task automatic serve(input int src, input logic we, input logic [24:0] addr,
                         input logic [7:0] wdata, input logic [7:0] rdata, input int delay,
                         input logic [7:0] exp_dout, input logic [2:0] drop_mask);
        logic       seen;
        logic [2:0] exp_ack;
        wait_strobe(seen);
        if (!seen) begin
            drop(drop_mask);
            return;
        end
        chk("strobe_rd", 32'(mem_rd), 32'(!we));
        chk("strobe_we", 32'(mem_we), 32'(we));
        chk("mem_addr", 32'(mem_addr), 32'(addr));
        if (we) chk("mem_dout", 32'(mem_dout), 32'(wdata));
        if (src == 1) chk("cpu_wait_busy", 32'(cpu_wait), 32'd1);
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            if (i == 0) chk("strobe_one_cycle", 32'({mem_rd, mem_we}), 32'd0);
            chk("addr_stable", 32'(mem_addr), 32'(addr));
            chk("no_early_ack", 32'({dl_ack, cpu_ack, bk_ack}), 32'd0);
        end
        mem_ready = 1'b1;
        mem_din   = rdata;
        @(negedge clk);
        mem_ready = 1'b0;
        mem_din   = 8'h00;
        exp_ack = 3'b100 >> src;
        chk("ack_owner", 32'({dl_ack, cpu_ack, bk_ack}), 32'(exp_ack));
        chk("bk_err_clear", 32'(bk_err), 32'd0);
        if (src == 1) begin
            chk("cpu_dout", 32'(cpu_dout), 32'(exp_dout));
            chk("cpu_wait_at_ack", 32'(cpu_wait), 32'd0);
        end
        if (src == 2) chk("bk_dout", 32'(bk_dout), 32'(exp_dout));
        drop(drop_mask);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   s0;
        int   n;
        logic seen;
        logic got_ack;

        vecs[0] = '{1, 1'b0, 25'h0004000,  8'h00, 8'h5A, 2, 8'h5A};
        vecs[1] = '{1, 1'b1, 25'h0004001,  8'h3C, 8'h00, 1, 8'h5A};
        vecs[2] = '{0, 1'b1, 25'h0000000,  8'hA5, 8'h00, 1, 8'h00};
        vecs[3] = '{2, 1'b1, 25'h0010000,  8'h12, 8'h00, 1, 8'h00};
        vecs[4] = '{2, 1'b0, 25'h0010001,  8'h00, 8'hC3, 3, 8'hC3};
        vecs[5] = '{1, 1'b0, 25'h1FFFFFF,  8'h00, 8'h81, 1, 8'h81};
        vecs[6] = '{2, 1'b1, 25'h1FFFFFF,  8'h7E, 8'h00, 5, 8'hC3};
        vecs[7] = '{0, 1'b1, 25'h1FFFFFF,  8'hFF, 8'h00, 4, 8'h00};

        reset = 1'b1;
        dl_req = 1'b0; cpu_req = 1'b0; bk_req = 1'b0; mem_ready = 1'b0;
        cpu_we = 1'b0; bk_we = 1'b0; mem_din = 8'h00;
        dl_addr = '0; cpu_addr = '0; bk_addr = '0;
        dl_data = 8'h00; cpu_din = 8'h00; bk_din = 8'h00;
        repeat (3) @(negedge clk);

        chk("rst_strobes", 32'({mem_rd, mem_we}), 32'd0);
        chk("rst_acks", 32'({dl_ack, cpu_ack, bk_ack}), 32'd0);
        chk("rst_bk_err", 32'(bk_err), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_dout", 32'(mem_dout), 32'd0);
        chk("rst_douts", 32'({cpu_dout, bk_dout}), 32'd0);
        chk("rst_cpu_wait", 32'(cpu_wait), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Single transactions, one requester at a time
        for (int v = 0; v < 8; v++) begin
            set_req(vecs[v].src, vecs[v].we, vecs[v].addr, vecs[v].wdata);
            serve(vecs[v].src, vecs[v].we, vecs[v].addr, vecs[v].wdata, vecs[v].rdata,
                  vecs[v].delay, vecs[v].exp_dout, 3'(3'b001 << vecs[v].src));
            @(negedge clk);
        end

        // All three requesters at once: dl, then cpu, then bk; one strobe each
        s0 = strobes;
        set_req(0, 1'b1, 25'h0000100, 8'h11);
        set_req(1, 1'b0, 25'h0004010, 8'h00);
        set_req(2, 1'b0, 25'h0010010, 8'h00);
        serve(0, 1'b1, 25'h0000100, 8'h11, 8'h00, 1, 8'h00, 3'b001);
        serve(1, 1'b0, 25'h0004010, 8'h00, 8'h22, 1, 8'h22, 3'b010);
        serve(2, 1'b0, 25'h0010010, 8'h00, 8'h99, 2, 8'h99, 3'b100);
        @(negedge clk);
        chk("three_strobes", 32'(strobes - s0), 32'd3);

        // CPU held with bk pending: four CPU grants, then bk, then CPU again
        set_req(1, 1'b0, 25'h0004020, 8'h00);
        set_req(2, 1'b1, 25'h0010020, 8'h44);
        for (int i = 0; i < 4; i++)
            serve(1, 1'b0, 25'h0004020, 8'h00, 8'(8'h30 + i), 1, 8'(8'h30 + i), 3'b000);
        serve(2, 1'b1, 25'h0010020, 8'h44, 8'h00, 1, 8'h99, 3'b000);
        serve(1, 1'b0, 25'h0004020, 8'h00, 8'h55, 1, 8'h55, 3'b110);
        @(negedge clk);

        // bk read that never gets mem_ready
        s0 = strobes;
        set_req(2, 1'b0, 25'h0002000, 8'h00);
        wait_strobe(seen);
        n = 0;
        got_ack = 1'b0;
        while (n < 400) begin
            @(negedge clk);
            n++;
            if (bk_ack) begin
                got_ack = 1'b1;
                break;
            end
        end
        chk("timeout_ack", 32'(got_ack), 32'd1);
        chk("timeout_latency_ok", 32'(n >= 255 && n <= 258), 32'd1);
        chk("timeout_bk_dout", 32'(bk_dout), 32'hFF);
        chk("timeout_bk_err", 32'(bk_err), 32'd1);
        chk("timeout_one_strobe", 32'(strobes - s0), 32'd1);
        drop(3'b100);
        @(negedge clk);
        chk("bk_err_sticky", 32'(bk_err), 32'd1);

        // Reset during WAIT, then a late mem_ready
        set_req(1, 1'b0, 25'h0004040, 8'h00);
        wait_strobe(seen);
        @(negedge clk);
        reset = 1'b1;
        cpu_req = 1'b0;
        @(negedge clk);
        chk("midrst_strobes", 32'({mem_rd, mem_we}), 32'd0);
        chk("midrst_acks", 32'({dl_ack, cpu_ack, bk_ack}), 32'd0);
        chk("midrst_douts", 32'({cpu_dout, bk_dout}), 32'd0);
        chk("midrst_bk_err", 32'(bk_err), 32'd0);
        reset = 1'b0;
        mem_ready = 1'b1;
        mem_din = 8'hEE;
        s0 = strobes;
        got_ack = 1'b0;
        @(negedge clk);
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (dl_ack || cpu_ack || bk_ack) got_ack = 1'b1;
            @(negedge clk);
        end
        chk("midrst_no_ack", 32'(got_ack), 32'd0);
        chk("midrst_no_strobe", 32'(strobes - s0), 32'd0);
        chk("midrst_cpu_dout", 32'(cpu_dout), 32'd0);

        set_req(1, 1'b0, 25'h0004080, 8'h00);
        serve(1, 1'b0, 25'h0004080, 8'h00, 8'h66, 2, 8'h66, 3'b010);
        @(negedge clk);
        chk("final_cpu_wait", 32'(cpu_wait), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
